// File: rtl/spi_ram_pkg.sv
// Shared command and arming types for the SPI RAM. The SPI slave and the
// verification components use the same definitions.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic {UNARMED, ARMED} arm_state_e;

endpackage

// File: rtl/spi_ram_mem_array.sv
// Single-port synchronous RAM with a read-enabled output register.
// The array itself is never reset; only the output register is cleared.
module spi_ram_mem_array #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [MEM_WIDTH-1:0] i_wdata,
  output logic [MEM_WIDTH-1:0] o_rdata
);

  logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // rdata only moves on a read, so it holds the last read value between reads
  always_ff @(posedge i_clk) begin
    if (i_rst)     o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI slave RAM with independent write/read pointers.
// It supports burst auto-increment, a 1- or 2-cycle read latency and command error pulses.
module spi_ram_burst import spi_ram_pkg::*; #(
  parameter int MEM_DEPTH    = 256,
  parameter int ADDR_SIZE    = 8,
  parameter int MEM_WIDTH    = 8,
  parameter int AUTO_INC     = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [MEM_WIDTH+1:0] din,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 tx_valid,
  output logic                 cmd_err
);

  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

  cmd_e                   w_cmd;
  arm_state_e             r_wr_st, w_wr_nxt, r_rd_st, w_rd_nxt;
  logic [ADDR_SIZE-1:0]   r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [ADDR_SIZE-1:0]   w_addr_ld, w_addr;
  logic                   w_we, w_re, w_err;
  logic [MEM_WIDTH-1:0]   w_rdata;
  logic [READ_LATENCY:1]  r_vld_pipe;

  function automatic logic [ADDR_SIZE-1:0] f_adv(input logic [ADDR_SIZE-1:0] p);
    if (AUTO_INC == 0) return p;
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_cmd     = cmd_e'(din[MEM_WIDTH+1:MEM_WIDTH]);
  assign w_addr_ld = ADDR_SIZE'(32'(din[ADDR_SIZE-1:0]) % MEM_DEPTH);

  always_comb begin
    w_wr_nxt     = r_wr_st;
    w_rd_nxt     = r_rd_st;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_we         = 1'b0;
    w_re         = 1'b0;
    w_err        = 1'b0;
    if (rx_valid) begin
      case (w_cmd)
        WR_ADDR: begin
          w_wr_nxt     = ARMED;
          w_wr_ptr_nxt = w_addr_ld;
        end
        WR_DATA: begin
          if (r_wr_st == ARMED) begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = f_adv(r_wr_ptr);
          end else w_err = 1'b1;
        end
        RD_ADDR: begin
          w_rd_nxt     = ARMED;
          w_rd_ptr_nxt = w_addr_ld;
        end
        RD_DATA: begin
          if (r_rd_st == ARMED) begin
            w_re         = 1'b1;
            w_rd_ptr_nxt = f_adv(r_rd_ptr);
          end else w_err = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_st  <= UNARMED;
      r_rd_st  <= UNARMED;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      cmd_err  <= 1'b0;
    end else begin
      r_wr_st  <= w_wr_nxt;
      r_rd_st  <= w_rd_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      cmd_err  <= w_err;
    end
  end

  // One command per cycle, so the single RAM port is never contended
  assign w_addr = w_we ? r_wr_ptr : r_rd_ptr;

  spi_ram_mem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE),
    .MEM_WIDTH (MEM_WIDTH)
  ) u_mem (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_wdata (din[MEM_WIDTH-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_vld_pipe <= '0;
    else begin
      r_vld_pipe[1] <= w_re;
      for (int i = 2; i <= READ_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  assign tx_valid = r_vld_pipe[READ_LATENCY];

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign dout = w_rdata;
    end else begin : g_lat2
      logic [MEM_WIDTH-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (rst)                r_dout <= '0;
        else if (r_vld_pipe[1]) r_dout <= w_rdata;
      end
      assign dout = r_dout;
    end
  endgenerate

endmodule
